// File: rtl/spart_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spart_driver_pkg
// Description : Shared types and constants for the SPART bus master: FSM
//               state encoding, SPART register addresses, baud-rate table
//               and the elaboration-time baud divisor function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package spart_driver_pkg;

  typedef enum logic [2:0] {
    CFG_LO = 3'd0,
    CFG_HI = 3'd1,
    POLL   = 3'd2,
    RD_RX  = 3'd3,
    WR_TX  = 3'd4
  } state_t;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  // Indexed by br_cfg
  localparam int unsigned BAUD_TABLE [4] = '{4800, 9600, 19200, 38400};

  // div = clk_hz / (16 * baud) - 1, truncated to 16 bits
  function automatic logic [15:0] baud_div(input int unsigned clk_hz,
                                           input logic [1:0]  br_cfg);
    int unsigned d;
    d = clk_hz / (32'd16 * BAUD_TABLE[br_cfg]) - 32'd1;
    return d[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/spart_driver_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spart_driver_fifo
// Description : Byte-wide synchronous FIFO holding received bytes until they
//               are echoed. DEPTH must be a power of two so the pointers wrap
//               naturally.
// Ports       : clk, rst (async, active-low), push/din, pop/dout (head, not
//               registered), full, empty, count (0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module spart_driver_fifo
  import spart_driver_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/spart_driver.sv
`default_nettype none
// ============================================================================
// Module      : spart_driver
// Description : Bus master for the SPART UART. Programs the baud divisor
//               selected by br_cfg, then runs a buffered echo loop: received
//               bytes are read into a local FIFO and written back to the
//               transmit buffer whenever the transmitter is free.
// Ports       : clk, rst (async, active-low), br_cfg[1:0] baud select,
//               iocs/iorw/ioaddr/databus SPART bus, rda/tbr SPART status,
//               fifo_cnt echo FIFO occupancy.
//               With SPART_DRIVER_STATS_EN defined: rx_count, tx_count,
//               ovr_count saturating statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module spart_driver
  import spart_driver_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    br_cfg,
  output logic                          iocs,
  output logic                          iorw,
  output logic [1:0]                    ioaddr,
  inout  wire  [7:0]                    databus,
  input  logic                          rda,
  input  logic                          tbr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
`ifdef SPART_DRIVER_STATS_EN
  ,
  output logic [15:0]                   rx_count,
  output logic [15:0]                   tx_count,
  output logic [7:0]                    ovr_count
`endif
);

  localparam logic [15:0] DIV_TBL [4] = '{
    baud_div(CLK_HZ, 2'd0), baud_div(CLK_HZ, 2'd1),
    baud_div(CLK_HZ, 2'd2), baud_div(CLK_HZ, 2'd3)
  };

  state_t     state;
  logic [1:0] br_cfg_q;
  logic [1:0] cfg_sel;
  logic       rx_armed;
  logic       tx_armed;
  logic [7:0] dout;
  logic       drive;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_head;

  assign databus = drive ? dout : 8'hzz;

  // Read data is captured at the end of the RD_RX bus cycle
  assign push = (state == RD_RX);
  assign pop  = (state == WR_TX);

  spart_driver_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (databus),
    .pop   (pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Bus outputs are registered alongside the state: the access belonging to
  // RD_RX / WR_TX is on the bus during that state's cycle. The config writes
  // are launched by the CFG_LO/CFG_HI edges, so the divisor-high write is
  // still on the bus during the first POLL cycle; TX is held off while the
  // bus shows a write so every TX write follows a non-write cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= CFG_LO;
      iocs     <= 1'b1;
      iorw     <= 1'b1;
      ioaddr   <= ADDR_STAT;
      dout     <= 8'h00;
      drive    <= 1'b0;
      br_cfg_q <= br_cfg;
      cfg_sel  <= br_cfg;
    end else begin
      iocs   <= 1'b0;
      iorw   <= 1'b1;
      ioaddr <= ADDR_STAT;
      drive  <= 1'b0;
      case (state)
        CFG_LO: begin
          iorw    <= 1'b0;
          ioaddr  <= ADDR_DBL;
          dout    <= DIV_TBL[br_cfg][7:0];
          drive   <= 1'b1;
          cfg_sel <= br_cfg;
          state   <= CFG_HI;
        end
        CFG_HI: begin
          // High byte uses the same selection as the low byte; a change in
          // between is caught by the mismatch check in POLL.
          iorw     <= 1'b0;
          ioaddr   <= ADDR_DBH;
          dout     <= DIV_TBL[cfg_sel][15:8];
          drive    <= 1'b1;
          br_cfg_q <= cfg_sel;
          state    <= POLL;
        end
        POLL: begin
          if (br_cfg != br_cfg_q) begin
            state <= CFG_LO;
          end else if (rda && rx_armed && !fifo_full) begin
            ioaddr <= ADDR_BUF;
            state  <= RD_RX;
          end else if (tbr && tx_armed && !fifo_empty && iorw) begin
            iorw   <= 1'b0;
            ioaddr <= ADDR_BUF;
            dout   <= fifo_head;
            drive  <= 1'b1;
            state  <= WR_TX;
          end
        end
        RD_RX:   state <= POLL;
        WR_TX:   state <= POLL;
        default: state <= CFG_LO;
      endcase
    end
  end

  // SPART holds rda/tbr high until the next byte event; a low level re-arms
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_armed <= 1'b0;
      tx_armed <= 1'b1;
    end else begin
      rx_armed <= !rda || (rx_armed && (state != RD_RX));
      tx_armed <= !tbr || (tx_armed && (state != WR_TX));
    end
  end

`ifdef SPART_DRIVER_STATS_EN
  logic rda_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rda_q     <= 1'b0;
      rx_count  <= 16'h0000;
      tx_count  <= 16'h0000;
      ovr_count <= 8'h00;
    end else begin
      rda_q <= rda;
      if (push && (rx_count != 16'hFFFF)) rx_count <= rx_count + 16'd1;
      if (pop && (tx_count != 16'hFFFF))  tx_count <= tx_count + 16'd1;
      // Still armed when rda falls means the byte was never read
      if (rda_q && !rda && rx_armed && (ovr_count != 8'hFF))
        ovr_count <= ovr_count + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/spart_driver.md
Name: spart_driver

Overview:
- Bus master for the SPART programmable UART; sits directly upstream of it on the iocs/iorw/ioaddr/databus interface.
- After reset it programs the baud divisor chosen by br_cfg. It then runs a buffered echo loop: poll status, read received bytes into a local FIFO, and write FIFO bytes back to the SPART transmit buffer whenever the transmitter is free.
- Serves as the bring-up and loopback engine for the board-level SPART demo.

Parameters:
- CLK_HZ, 50000000, system clock frequency used to compute baud divisors at elaboration.
- FIFO_DEPTH, 8, echo FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- br_cfg  input  2  baud select: 00=4800, 01=9600, 10=19200, 11=38400
- iocs  output  1  SPART chip select, active-low
- iorw  output  1  1=read, 0=write
- ioaddr  output  2  00=RX/TX buffer, 01=status, 10=divisor low, 11=divisor high
- databus  inout  8  driven by driver only when iocs=0 and iorw=0; otherwise Z
- rda  input  1  SPART receive data available (level)
- tbr  input  1  SPART transmit buffer ready (level)
- fifo_cnt  output  $clog2(FIFO_DEPTH)+1  current echo FIFO occupancy (debug/LED)

Behaviour:
- Reset values: iocs=1, iorw=1, ioaddr=01, databus=Z, fifo_cnt=0, FSM=CFG_LO, rx_armed=0, tx_armed=1, br_cfg_q=br_cfg.
- Divisor: div = CLK_HZ/(16*baud) - 1, truncated, 16 bits. At 50 MHz: 4800=0x028A, 9600=0x0144, 19200=0x00A1, 38400=0x0050.
- All bus outputs are registered. Each access lasts exactly one cycle.
- Read data is sampled from databus at the end of the RD_RX cycle.
- Idle bus state (POLL) is iocs=0, iorw=1, ioaddr=01. Every TX write is therefore preceded by a non-write cycle, so the SPART sees a fresh write edge for each byte.
- FSM states:
  - CFG_LO: write div[7:0] to ioaddr 10 -> CFG_HI.
  - CFG_HI: write div[15:8] to ioaddr 11; latch br_cfg_q -> POLL.
  - POLL: evaluate in priority order.
    1. br_cfg != br_cfg_q -> CFG_LO. Reconfiguration beats pending data; FIFO contents are retained.
    2. rda & rx_armed & FIFO not full -> RD_RX.
    3. tbr & tx_armed & FIFO not empty -> WR_TX.
    4. Otherwise stay in POLL.
  - RD_RX: read ioaddr 00, push byte, clear rx_armed -> POLL.
  - WR_TX: write FIFO head to ioaddr 00, pop, clear tx_armed -> POLL.
- Arming flags (the SPART holds rda and tbr high until the next byte event):
  - rx_armed sets on any cycle rda=0.
  - tx_armed sets on any cycle tbr=0.
  - These flags prevent double-reading a byte and prevent writing before the previous transmission has started.
- Simultaneous rda and tbr qualify: RX wins. TX is serviced on the next POLL pass, so the worst-case TX delay is 2 cycles.
- FIFO full while rda is armed: the byte is not read. The SPART overwrites it when the next byte arrives, and the loss is tolerated.
- FIFO empty: no TX write, even when tbr=1.
- Push and pop never occur in the same cycle, because the FSM serialises them.
- Pointers wrap modulo FIFO_DEPTH. fifo_cnt counts 0..FIFO_DEPTH.
- Reset asserted mid-access: outputs return to reset values immediately (asynchronous), FIFO is cleared, and configuration restarts on release.

Optional Feature:
- Macro: SPART_DRIVER_STATS_EN.
- Defined: adds outputs rx_count[15:0] (bytes read), tx_count[15:0] (bytes written) and ovr_count[7:0] (rda fell while rx_armed=1 without having been read). All three counters saturate at max and reset to 0.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package spart_driver_pkg contains:
  - state enum (CFG_LO, CFG_HI, POLL, RD_RX, WR_TX)
  - ioaddr constants ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH
  - baud rate table
  - function baud_div(clk_hz, br_cfg) returning 16 bits
- One sub-module, spart_driver_fifo: synchronous FIFO with push/pop/full/empty/count, parameter DEPTH, width 8, async active-low reset.

Test Plan:
- Reset release with br_cfg=01, CLK_HZ=50e6 -> cycle 1 writes 0x44 at ioaddr 10; cycle 2 writes 0x01 at ioaddr 11; then iocs=0/iorw=1/ioaddr=01 held.
- rda=1 with databus model returning 0x5A, tbr=1 -> one read at 00, then one write of 0x5A at 00. No second read until rda has gone low; no second write until tbr has gone low.
- 9 bytes received with tbr held 0 (FIFO_DEPTH=8) -> 8 reads, fifo_cnt=8, 9th byte not read. Raise tbr with pulses -> bytes echoed in order 1..8.
- rda and tbr both qualifying in the same POLL cycle with FIFO holding 0x11 -> RD_RX first, WR_TX of 0x11 on the next pass.
- br_cfg changed 01->11 while FIFO holds 3 bytes -> writes 0x50 then 0x00 to divisor registers; fifo_cnt stays 3; echo resumes.
- rst asserted during WR_TX -> databus Z and iocs=1 in the same cycle; fifo_cnt=0; CFG_LO after release. With SPART_DRIVER_STATS_EN defined, all counters read 0.
